fir_mc: RTL and testbench

Time-multiplexed, multi-channel serial-MAC FIR filter. It is the parametrised successor to the team's single-channel fixed-coefficient FIR.
- Each channel keeps its own delay line. All channels share one coefficient RAM, which is writable at run time.
- Output uses round-half-up and saturation, and is delivered over a valid/ready handshake.
- Sits between the sample acquisition front end and the downstream state-machine/decimation logic.

---
 rtl/fir_mc_pkg.sv | 50 +++++
 rtl/fir_mc_coef_ram.sv | 31 +++
 rtl/fir_mc.sv | 154 +++++++++++++++
 tb/tb_fir_mc.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mc_pkg.sv
// Shared types and helpers for the multi-channel serial-MAC FIR.
// Holds the controller state encoding, accumulator sizing and output rounding.
package fir_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Wide enough for any accumulator and output width this block is built with.
  localparam int RS_W      = 128;
  localparam int OUT_MAX_W = 64;

  typedef struct packed {
    logic signed [OUT_MAX_W-1:0] value;
    logic                        sat;
  } round_t;

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Round half up, drop the fractional bits, then clamp into a signed dw-bit range.
  function automatic round_t round_sat(input logic signed [RS_W-1:0] acc,
                                       input int frac, input int dw);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    round_t                 res;
    one = 1;
    r   = (acc + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    if (r > hi) begin
      res.value = OUT_MAX_W'(hi);
      res.sat   = 1'b1;
    end else if (r < lo) begin
      res.value = OUT_MAX_W'(lo);
      res.sat   = 1'b1;
    end else begin
      res.value = OUT_MAX_W'(r);
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mc_coef_ram.sv
// Shared coefficient store: one synchronous write port, one asynchronous read port.
// Cleared to zero on reset so an unprogrammed filter produces zero output.
module fir_mc_coef_ram #(
  parameter  int CW   = 20,
  parameter  int TAPS = 20,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [CW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [CW-1:0] rdata
);

  logic signed [CW-1:0] r_mem [TAPS];

  // NOTE: this memory is reset (flops, not a RAM macro) because cleared coefficients
  // are architecturally visible after reset; NOTE: sequential state uses <= only.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel FIR: one MAC per clock over TAPS taps per sample,
// per-channel delay lines, shared run-time coefficients, rounded/saturated output.
module fir_mc
  import fir_mc_pkg::*;
#(
  parameter  int DW   = 20,
  parameter  int CW   = 20,
  parameter  int TAPS = 20,
  parameter  int CH   = 2,
  parameter  int FRAC = 19,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic [CHW-1:0]       in_ch,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [CHW-1:0]       out_ch,
  output logic                 sat_flag,
  output logic                 ch_err
);

  localparam int              ACCW      = acc_width(DW, CW, TAPS);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(TAPS - 1);
  localparam logic [CHW:0]    CH_LIM    = (CHW + 1)'(CH);

  state_t                  r_state;
  state_t                  w_next;
  logic [AW-1:0]           r_addr;
  logic signed [ACCW-1:0]  r_acc;
  logic [CHW-1:0]          r_ch;
  logic signed [DW-1:0]    r_line [CH][TAPS];
  logic                    r_out_valid;
  logic signed [DW-1:0]    r_out_data;
  logic [CHW-1:0]          r_out_ch;
  logic                    r_sat;
  logic                    r_ch_err;

  logic                    w_accept;
  logic                    w_ch_ok;
  logic                    w_coef_wr;
  logic signed [CW-1:0]    w_coef;
  logic signed [DW-1:0]    w_tap;
  logic signed [DW+CW-1:0] w_prod;
  round_t                  w_round;

  // clr takes priority over a sample in the same cycle by withdrawing in_ready.
  assign in_ready  = (r_state == IDLE) && !clr;
  assign w_accept  = in_ready && in_valid;
  assign w_ch_ok   = {1'b0, in_ch} < CH_LIM;
  assign w_coef_wr = (r_state == IDLE) && coef_we && !w_accept;

  fir_mc_coef_ram #(
    .CW   (CW),
    .TAPS (TAPS)
  ) u_coef_ram (
    .ck    (ck),
    .rst   (rst),
    .we    (w_coef_wr),
    .waddr (coef_addr),
    .wdata (coef_data),
    .raddr (r_addr),
    .rdata (w_coef)
  );

  assign w_tap   = r_line[r_ch][r_addr];
  assign w_prod  = w_tap * w_coef;
  assign w_round = round_sat(RS_W'(r_acc), FRAC, DW);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: next state defaults to the current one so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_ch_ok)  w_next = MAC;
      MAC:     if (r_addr == LAST_ADDR)  w_next = ROUND;
      ROUND:                             w_next = OUT;
      OUT:     if (out_ready)            w_next = IDLE;
      default:                           w_next = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_acc       <= '0;
      r_ch        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_sat       <= 1'b0;
      r_ch_err    <= 1'b0;
    end else begin
      r_ch_err <= w_accept && !w_ch_ok;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ch   <= in_ch;
            r_acc  <= '0;
            r_addr <= '0;
          end
        end
        MAC: begin
          r_acc  <= r_acc + ACCW'(w_prod);
          r_addr <= r_addr + 1'b1;
        end
        ROUND: begin
          r_out_data  <= DW'(w_round.value);
          r_sat       <= w_round.sat;
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Delay lines only move in IDLE, so the MAC sweep always sees a frozen snapshot.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < TAPS; i++) r_line[c][i] <= '0;
    end else if ((r_state == IDLE) && clr) begin
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < TAPS; i++) r_line[c][i] <= '0;
    end else if (w_accept && w_ch_ok) begin
      for (int i = TAPS - 1; i > 0; i--) r_line[in_ch][i] <= r_line[in_ch][i-1];
      r_line[in_ch][0] <= in_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign sat_flag  = r_sat;
  assign ch_err    = r_ch_err;

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc: a behavioural model predicts each result on accept,
// a negedge monitor pops and compares when the DUT hands a result over.
module tb_fir_mc;

  localparam int DW   = 20;
  localparam int CW   = 20;
  localparam int TAPS = 20;
  localparam int CH   = 3;   // three channels so in_ch has a representable illegal value
  localparam int FRAC = 19;
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW   = $clog2(TAPS);

  logic                 ck = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [CHW-1:0]       in_ch;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 clr;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [CHW-1:0]       out_ch;
  logic                 sat_flag;
  logic                 ch_err;

  always #5 ck = ~ck;

  fir_mc #(.DW(DW), .CW(CW), .TAPS(TAPS), .CH(CH), .FRAC(FRAC)) dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .sat_flag(sat_flag), .ch_err(ch_err)
  );

  typedef struct {
    longint data;
    int     ch;
    bit     sat;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  longint m_coef [TAPS];
  longint m_line [CH][TAPS];
  int     n_checks = 0;
  int     n_pass   = 0;

  function automatic void model_reset_lines();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < TAPS; i++) m_line[c][i] = 0;
  endfunction

  function automatic void model_push(input int ch, input longint x);
    longint acc, r, hi, lo;
    exp_t   e;
    for (int i = TAPS - 1; i > 0; i--) m_line[ch][i] = m_line[ch][i-1];
    m_line[ch][0] = x;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += m_line[ch][i] * m_coef[i];
    r  = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    e.ch  = ch;
    e.sat = (r > hi) || (r < lo);
    e.data = (r > hi) ? hi : ((r < lo) ? lo : r);
    sb_q.push_back(e);
  endfunction

  // Result monitor: a transfer happens at the posedge following a negedge with valid&ready.
  always @(negedge ck) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_output: got data=%0d ch=%0d, expected no output",
                 out_data, out_ch);
      end else begin
        mon_e = sb_q.pop_front();
        if (longint'(out_data) !== mon_e.data || int'(out_ch) !== mon_e.ch ||
            sat_flag !== mon_e.sat)
          $display("FAIL result: got data=%0d ch=%0d sat=%0b, expected data=%0d ch=%0d sat=%0b",
                   out_data, out_ch, sat_flag, mon_e.data, mon_e.ch, mon_e.sat);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge ck);
    while ((sb_q.size() != 0 || !in_ready) && t < 400) begin
      @(negedge ck);
      t++;
    end
    n_checks++;
    if (t >= 400) $display("FAIL idle_timeout: pending=%0d in_ready=%0b, expected 0 and 1",
                           sb_q.size(), in_ready);
    else n_pass++;
  endtask

  task automatic send(input int ch, input longint x);
    int t = 0;
    @(negedge ck);
    while (!in_ready && t < 200) begin
      @(negedge ck);
      t++;
    end
    n_checks++;
    if (t >= 200) $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
    else n_pass++;
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    in_data  = x[DW-1:0];
    @(posedge ck);
    #1 in_valid = 1'b0;
    if (ch < CH) model_push(ch, x);
  endtask

  task automatic write_coef(input int a, input longint v);
    @(negedge ck);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = v[CW-1:0];
    @(posedge ck);
    #1 coef_we = 1'b0;
    m_coef[a] = v;
  endtask

  task automatic load_coefs(input longint v0, input longint v1, input longint vrest);
    wait_idle();
    for (int i = 0; i < TAPS; i++) write_coef(i, (i == 0) ? v0 : ((i == 1) ? v1 : vrest));
  endtask

  task automatic do_clr();
    wait_idle();
    @(negedge ck);
    clr = 1'b1;
    @(posedge ck);
    #1 clr = 1'b0;
    model_reset_lines();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
    model_reset_lines();
    repeat (2) @(negedge ck);
    n_checks += 6;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); else n_pass++;
    if (out_data !== '0)    $display("FAIL reset_out_data: got %0d, expected 0", out_data);   else n_pass++;
    if (out_ch !== '0)      $display("FAIL reset_out_ch: got %0d, expected 0", out_ch);       else n_pass++;
    if (sat_flag !== 1'b0)  $display("FAIL reset_sat_flag: got %0b, expected 0", sat_flag);   else n_pass++;
    if (ch_err !== 1'b0)    $display("FAIL reset_ch_err: got %0b, expected 0", ch_err);       else n_pass++;
    if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);   else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    int cnt = 0;
    load_coefs(262144, 262144, 262144);
    do_clr();
    send(0, 1000);
    while (cnt < 100) begin
      @(negedge ck);
      if (out_valid) break;
      @(posedge ck);
      cnt++;
    end
    n_checks++;
    if (cnt !== TAPS + 1) $display("FAIL impulse_latency: got %0d edges, expected %0d", cnt, TAPS + 1);
    else n_pass++;
    send(0, 0);
    wait_idle();
  endtask

  task automatic test_rounding();
    load_coefs(1, 0, 0);
    do_clr();
    send(0, 262144);
    send(0, 262143);
    send(0, -262144);
    send(0, -262145);
    wait_idle();
  endtask

  task automatic test_saturation();
    load_coefs(524287, 524287, 524287);
    do_clr();
    for (int i = 0; i < TAPS; i++) send(0, 524287);
    do_clr();
    for (int i = 0; i < TAPS; i++) send(0, -524288);
    wait_idle();
  endtask

  task automatic test_clr_conflict();
    wait_idle();
    @(negedge ck);
    clr = 1'b1; in_valid = 1'b1; in_ch = '0; in_data = DW'(5000);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL clr_in_ready: got %0b, expected 0", in_ready); else n_pass++;
    @(posedge ck);
    #1 clr = 1'b0; in_valid = 1'b0;
    model_reset_lines();
    @(negedge ck);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL clr_no_accept: in_ready got %0b, expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_channels();
    load_coefs(262144, 262144, 0);
    do_clr();
    send(0, 1000);
    send(1, 2000);
    send(0, 0);
    send(2, 300);
    wait_idle();
    send(3, 777);
    @(negedge ck);
    n_checks += 2;
    if (ch_err !== 1'b1)   $display("FAIL ch_err_pulse: got %0b, expected 1", ch_err);     else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL ch_err_idle: in_ready got %0b, expected 1", in_ready); else n_pass++;
    @(negedge ck);
    n_checks++;
    if (ch_err !== 1'b0) $display("FAIL ch_err_width: got %0b, expected 0", ch_err); else n_pass++;
    repeat (TAPS + 4) @(negedge ck);
    send(2, 0);
    wait_idle();
  endtask

  task automatic test_backpressure();
    int t = 0;
    load_coefs(262144, -131072, 0);
    do_clr();
    out_ready = 1'b0;
    send(0, 4000);
    coef_we = 1'b1; coef_addr = '0; coef_data = CW'(100000);
    repeat (3) @(posedge ck);
    #1 coef_we = 1'b0;
    @(negedge ck);
    while (!out_valid && t < 100) begin
      @(negedge ck);
      t++;
    end
    n_checks++;
    if (t >= 100) $display("FAIL bp_valid_timeout: out_valid got %0b, expected 1", out_valid); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(posedge ck);
      #1 coef_we = 1'b1; coef_addr = AW'(1); coef_data = CW'(77);
      @(negedge ck);
      n_checks += 4;
      if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %0b, expected 1", out_valid); else n_pass++;
      if (in_ready !== 1'b0)  $display("FAIL bp_in_ready: got %0b, expected 0", in_ready);   else n_pass++;
      if (sb_q.size() == 0)   $display("FAIL bp_hold_data: got %0d, expected a pending result", out_data);
      else if (longint'(out_data) !== sb_q[0].data)
        $display("FAIL bp_hold_data: got %0d, expected %0d", out_data, sb_q[0].data);
      else n_pass++;
      if (sb_q.size() != 0 && int'(out_ch) !== sb_q[0].ch)
        $display("FAIL bp_hold_ch: got %0d, expected %0d", out_ch, sb_q[0].ch);
      else n_pass++;
    end
    @(posedge ck);
    #1 coef_we = 1'b0; out_ready = 1'b1;
    wait_idle();
    send(0, 0);
    wait_idle();
  endtask

  task automatic test_reset_mid_mac();
    wait_idle();
    send(1, 1000);
    repeat (4) @(posedge ck);
    #1 rst = 1'b1;
    void'(sb_q.pop_back());
    for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
    model_reset_lines();
    @(posedge ck);
    #1 rst = 1'b0;
    @(negedge ck);
    n_checks += 2;
    if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %0b, expected 0", out_valid); else n_pass++;
    if (in_ready !== 1'b1)  $display("FAIL rst_mid_ready: got %0b, expected 1", in_ready);  else n_pass++;
    repeat (TAPS + 4) @(negedge ck);
    send(1, 1000);
    wait_idle();
    load_coefs(262144, 0, 0);
    send(1, 600);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_clr_conflict();
    test_channels();
    test_backpressure();
    test_reset_mid_mac();
    wait_idle();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL drain: pending got %0d, expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
